// File: rtl/nibble_add_sched_pkg.sv
// Shared types and constants for the nibble-serial add/subtract scheduler.
package nibble_add_sched_pkg;

   // Bits handled per pass by the nibble adder.
   localparam int NIB_W = 4;

   // Top-level control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_add_sched_if.sv
// Request/response bundle between two requesters, the scheduler and the result consumer.
interface nibble_add_sched_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_sub;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_sub;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_ovf;
   logic             res_id;

   logic             busy;

   // Requesters and result consumer side.
   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_sum, res_cout, res_ovf, res_id, busy
   );

   // Scheduler side.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_sum, res_cout, res_ovf, res_id, busy
   );
endinterface

// File: rtl/nibble_add_sched_fourbitadder.sv
// 4-bit ripple-carry adder: the only arithmetic element of the scheduler.
module fourbitadder (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   // One full adder per bit, carry rippling upward.
   for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
      assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
   end

   assign cout = c[4];

endmodule

// File: rtl/nibble_add_sched.sv
// Two-requester round-robin scheduler that performs WIDTH-bit add/subtract
// one nibble per cycle through a single shared 4-bit adder.
module nibble_add_sched
   import nibble_add_sched_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   nibble_add_sched_if.slave bus
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t             state_reg;
   state_t             state_next;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;       // already inverted for subtract
   logic [WIDTH-1:0]   work_reg;    // partial sum built nibble by nibble
   logic               id_reg;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic               last_reg;    // requester granted most recently

   logic [WIDTH-1:0]   res_sum_reg;
   logic               res_cout_reg;
   logic               res_ovf_reg;
   logic               res_id_reg;

   logic               grant_any;
   logic               grant_id;
   logic               last_pass;
   logic [NIB_W-1:0]   nib_a;
   logic [NIB_W-1:0]   nib_b;
   logic [NIB_W-1:0]   nib_s;
   logic               nib_cout;
   logic [WIDTH-1:0]   full_sum;

   assign last_pass = (idx_reg == IDX_W'(NIB - 1));
   assign nib_a     = a_reg[int'(idx_reg)*NIB_W +: NIB_W];
   assign nib_b     = b_reg[int'(idx_reg)*NIB_W +: NIB_W];

   fourbitadder u_adder (
      .x    (nib_a),
      .y    (nib_b),
      .cin  (carry_reg),
      .s    (nib_s),
      .cout (nib_cout)
   );

   // Round-robin pick: a lone valid wins, a tie goes to the requester not served last.
   always_comb begin
      grant_any = bus.req0_valid | bus.req1_valid;
      grant_id  = (bus.req0_valid && bus.req1_valid) ? ~last_reg : bus.req1_valid;
   end

   // Current partial sum with this cycle's nibble merged in.
   always_comb begin
      full_sum = work_reg;
      full_sum[int'(idx_reg)*NIB_W +: NIB_W] = nib_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any)     state_next = RUN;
         RUN:     if (last_pass)     state_next = DONE;
         DONE:    if (bus.res_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Handshake and status outputs; ready is held low while reset is asserted.
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.res_valid  = 1'b0;
      bus.busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (!rst && grant_any) begin
               bus.req0_ready = ~grant_id;
               bus.req1_ready = grant_id;
            end
         end
         DONE:    bus.res_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, nibble passes and result latching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         work_reg     <= '0;
         id_reg       <= 1'b0;
         carry_reg    <= 1'b0;
         idx_reg      <= '0;
         last_reg     <= 1'b1;
         res_sum_reg  <= '0;
         res_cout_reg <= 1'b0;
         res_ovf_reg  <= 1'b0;
         res_id_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_any) begin
                  if (grant_id) begin
                     a_reg     <= bus.req1_a;
                     b_reg     <= bus.req1_b ^ {WIDTH{bus.req1_sub}};
                     carry_reg <= bus.req1_sub;
                  end else begin
                     a_reg     <= bus.req0_a;
                     b_reg     <= bus.req0_b ^ {WIDTH{bus.req0_sub}};
                     carry_reg <= bus.req0_sub;
                  end
                  id_reg   <= grant_id;
                  last_reg <= grant_id;
                  idx_reg  <= '0;
               end
            end
            RUN: begin
               work_reg  <= full_sum;
               carry_reg <= nib_cout;
               idx_reg   <= idx_reg + IDX_W'(1);
               if (last_pass) begin
                  res_sum_reg  <= full_sum;
                  res_cout_reg <= nib_cout;
                  res_ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                  (full_sum[WIDTH-1] != a_reg[WIDTH-1]);
                  res_id_reg   <= id_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.res_sum  = res_sum_reg;
   assign bus.res_cout = res_cout_reg;
   assign bus.res_ovf  = res_ovf_reg;
   assign bus.res_id   = res_id_reg;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench for nibble_add_sched: acceptances push model results,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_nibble_add_sched;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         id;
      int           acc_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   nibble_add_sched_if #(.WIDTH(W)) bus ();

   nibble_add_sched #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cycle_cnt = 0;
   exp_t exp_q[$];
   logic model_last = 1'b1;

   logic         prev_valid = 1'b0;
   logic         prev_hold = 1'b0;
   logic [W-1:0] hold_sum;
   logic         hold_cout, hold_ovf, hold_id;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic id);
      exp_t   m;
      longint ua, ub, sa, sb, r, sr;
      longint smax, smin;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      if (sub) begin
         r      = ua - ub;
         sr     = sa - sb;
         m.cout = (ua >= ub);
      end else begin
         r      = ua + ub;
         sr     = sa + sb;
         m.cout = (r >= (longint'(1) << W));
      end
      m.sum     = r[W-1:0];
      m.ovf     = (sr > smax) || (sr < smin);
      m.id      = id;
      m.acc_cyc = 0;
      return m;
   endfunction

   always @(posedge clk) cycle_cnt++;

   // Monitor: result checks, stability under backpressure, grant checks.
   always @(negedge clk) begin
      exp_t e;
      logic acc0, acc1, want;
      if (rst) begin
         prev_valid = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         if (bus.res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_res_valid: got 1 expected 0");
            end else begin
               chk("latency", W'(cycle_cnt - exp_q[0].acc_cyc), W'(NIB));
            end
         end
         if (prev_hold && bus.res_valid) begin
            chk("hold_sum", bus.res_sum, hold_sum);
            chk("hold_cout", W'(bus.res_cout), W'(hold_cout));
            chk("hold_ovf", W'(bus.res_ovf), W'(hold_ovf));
            chk("hold_id", W'(bus.res_id), W'(hold_id));
         end
         if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sum", bus.res_sum, e.sum);
            chk("cout", W'(bus.res_cout), W'(e.cout));
            chk("ovf", W'(bus.res_ovf), W'(e.ovf));
            chk("id", W'(bus.res_id), W'(e.id));
            $display("result id=%0d sum=%h cout=%0d ovf=%0d", bus.res_id, bus.res_sum,
                     bus.res_cout, bus.res_ovf);
         end
         prev_hold  = bus.res_valid && !bus.res_ready;
         hold_sum   = bus.res_sum;
         hold_cout  = bus.res_cout;
         hold_ovf   = bus.res_ovf;
         hold_id    = bus.res_id;
         prev_valid = bus.res_valid;

         if (bus.busy) chk("ready_while_busy", W'(bus.req0_ready | bus.req1_ready), W'(0));

         acc0 = bus.req0_valid && bus.req0_ready;
         acc1 = bus.req1_valid && bus.req1_ready;
         if (acc0 || acc1) begin
            chk("ready_excl", W'(bus.req0_ready && bus.req1_ready), W'(0));
            want = (bus.req0_valid && bus.req1_valid) ? ~model_last : bus.req1_valid;
            chk("grant", W'(acc1), W'(want));
            model_last = acc1;
            if (acc1) e = model(bus.req1_a, bus.req1_b, bus.req1_sub, 1'b1);
            else      e = model(bus.req0_a, bus.req0_b, bus.req0_sub, 1'b0);
            e.acc_cyc = cycle_cnt + 1;
            exp_q.push_back(e);
            $display("accept id=%0d", acc1);
         end
      end
   end

   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
      bit got = 1'b0;
      @(posedge clk);
      #1;
      if (id) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
      end
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (id ? bus.req1_ready : bus.req0_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   task automatic stream(input logic id, input int n_ops);
      for (int k = 0; k < n_ops; k++)
         issue(id, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_res_valid", W'(bus.res_valid), W'(0));
      chk("rst_busy", W'(bus.busy), W'(0));
      chk("rst_ready", W'({bus.req1_ready, bus.req0_ready}), W'(0));
      chk("rst_res_sum", bus.res_sum, W'(0));
      chk("rst_res_cout", W'(bus.res_cout), W'(0));
      chk("rst_res_ovf", W'(bus.res_ovf), W'(0));
      chk("rst_res_id", W'(bus.res_id), W'(0));
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      model_last = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
      bus.res_ready  = 1'b1;

      // Reset state, with a requester already knocking.
      bus.req0_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      #1;
      rst = 1'b0;

      // Directed vectors.
      issue(1'b0, 16'h1234, 16'h0FFF, 1'b0);
      wait_drain();
      issue(1'b1, 16'h0001, 16'h0002, 1'b1);
      wait_drain();
      issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      wait_drain();
      issue(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      wait_drain();
      issue(1'b0, 16'h8000, 16'h0001, 1'b1);
      wait_drain();

      // Backpressure: hold the result for 5 cycles.
      bus.res_ready = 1'b0;
      issue(1'b1, W'($urandom), W'($urandom), 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_res_valid_seen", W'(seen), W'(1));
      repeat (5) begin
         @(negedge clk);
         chk("bp_busy", W'(bus.busy), W'(1));
      end
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_busy", W'(bus.busy), W'(0));
      chk("bp_idle_valid", W'(bus.res_valid), W'(0));

      // Random single-requester traffic.
      for (int k = 0; k < 30; k++)
         issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      wait_drain();

      // Contention from a fresh reset: grants must alternate starting with 0.
      pulse_reset();
      fork
         stream(1'b0, 6);
         stream(1'b1, 6);
      join
      wait_drain();

      // Reset during the third nibble pass aborts the operation.
      issue(1'b0, 16'h5A5A, 16'h3C3C, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_last = 1'b1;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk("post_abort_valid", W'(bus.res_valid), W'(0));
      end
      issue(1'b1, 16'h0102, 16'h0304, 1'b0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_add_sched.md
NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, a multiple of 4 and at least 8.
REQ-002 SHALL derive the local constant NIB = WIDTH/4, the number of nibble passes per operation.
REQ-003 clk  in  1: single clock, rising-edge.
REQ-004 rst  in  1: reset, asynchronous and active-high.
REQ-005 req0_valid  in  1: requester 0 has an operation pending.
REQ-006 req0_ready  out  1: requester 0 operation accepted this cycle.
REQ-007 req0_a, req0_b  in  WIDTH: requester 0 operands.
REQ-008 req0_sub  in  1: requester 0 selects a-b (1) or a+b (0).
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as REQ-005..008, for requester 1.
REQ-010 res_valid  out  1: result available.
REQ-011 res_ready  in  1: consumer accepts the result.
REQ-012 res_sum  out  WIDTH: result bits.
REQ-013 res_cout  out  1: final carry-out (for sub: 1 = no borrow).
REQ-014 res_ovf  out  1: signed two's-complement overflow.
REQ-015 res_id  out  1: requester that owns the result.
REQ-016 busy  out  1: high whenever state is not IDLE.

Function
REQ-017 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-018 In IDLE with at least one valid, SHALL grant one requester and assert only that requester's ready combinationally in that cycle; acceptance = valid && ready at the rising edge.
REQ-019 Arbitration SHALL be round-robin: single valid wins; both valid -> the requester not granted last wins; after reset requester 0 has priority.
REQ-020 On acceptance SHALL register a, b XOR {WIDTH{sub}}, sub, and requester id; carry register <= sub; nibble index <= 0; state -> RUN.
REQ-021 SHALL ignore valid outside IDLE; ready SHALL be 0 in RUN and DONE.
REQ-022 In RUN, each cycle SHALL add nibble[idx] of a and b with the carry register through one 4-bit adder, write the 4 sum bits to result nibble[idx], load carry-out into the carry register, and increment idx.
REQ-023 After the pass with idx = NIB-1, SHALL go to DONE; res_valid rises exactly NIB cycles after the acceptance edge (4 for WIDTH=16).
REQ-024 In DONE, SHALL hold res_valid and all res_* stable until res_valid && res_ready, then return to IDLE at that edge; a new grant happens in IDLE no earlier than the next cycle.
REQ-025 res_cout SHALL equal the carry register after the last pass.
REQ-026 res_ovf SHALL be 1 iff the registered a[MSB] equals the registered (inverted for sub) b[MSB] and res_sum[MSB] differs from them.
REQ-027 Results SHALL be modulo 2^WIDTH; the carry SHALL wrap out only through res_cout.
REQ-028 Minimum issue interval SHALL be NIB+2 cycles per operation when res_ready is held high.
REQ-029 res_valid SHALL be 0 in IDLE and RUN; res_sum/res_cout/res_ovf/res_id SHALL retain their last values outside DONE.

Reset
REQ-030 rst SHALL asynchronously force: state IDLE, res_valid 0, res_sum 0, res_cout 0, res_ovf 0, res_id 0, busy 0, both ready 0, carry 0, idx 0, round-robin pointer giving requester 0 priority.
REQ-031 rst asserted mid-RUN or mid-DONE SHALL abort the operation with no result produced; the aborted requester is not re-served unless it re-presents valid.
REQ-032 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-033 The shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the nibble width constant 4.
REQ-034 SHALL instantiate exactly one sub-module, the existing fourbitadder (x, y, cin -> s, cout), as the only arithmetic element; no WIDTH-wide adder SHALL be inferred.
REQ-035 Operand, result, carry, idx and arbitration registers SHALL live in nibble_add_sched.

Verification
REQ-036 Single add: req0 a=0x1234 b=0x0FFF sub=0 -> res_valid 4 cycles after acceptance, sum=0x2233, cout=0, ovf=0, id=0.
REQ-037 Subtract with borrow: req1 a=0x0001 b=0x0002 sub=1 -> sum=0xFFFF, cout=0, ovf=0, id=1.
REQ-038 Overflow and wrap: a=0x7FFF b=0x0001 add -> sum=0x8000, ovf=1, cout=0; a=0xFFFF b=0x0001 add -> sum=0x0000, cout=1, ovf=0.
REQ-039 Contention: both valid continuously -> grants alternate 0,1,0,1 starting with 0; each id matches its operands; ready is never high for both requesters.
REQ-040 Backpressure: res_ready low for 5 cycles in DONE -> res_* stable, busy=1, no ready asserted; res_ready high -> IDLE at the next edge.
REQ-041 Reset mid-RUN at nibble pass 2 -> all outputs match REQ-030 immediately; no res_valid until a fresh acceptance.
